freq_gate_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/freq_gate_meter_gate_timer.sv | 33 +++
 rtl/freq_gate_meter.sv | 170 +++++++++++++++++
 tb/tb_freq_gate_meter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gate-window frequency meter.
//   CNT_W_DEF      default width of the crossing count and frequency result
//   state_e        meter state machine encoding
//   sat_mul_width  width needed to hold count * scale before saturation
package freq_meter_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    MEASURE = 2'd2
  } state_e;

  // Full-width product of a w-bit count and a constant scale factor.
  function automatic int unsigned sat_mul_width(input int unsigned w, input int unsigned scale);
    return w + $clog2(scale + 1);
  endfunction

endpackage

// File: rtl/freq_gate_meter_gate_timer.sv
// Gate window timer.
//   clk   system clock
//   rstn  asynchronous active-low reset
//   run   counter advances while high, held at 0 while low
//   tick  high in the last cycle of each GATE_CYCLES-long window
module gate_timer #(
  parameter int unsigned GATE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Not gated by run: a sample still happens on the tick cycle that run falls.
  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (!run || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/freq_gate_meter.sv
// Gate-window frequency meter: samples a cumulative crossing count once per
// gate and converts the per-gate increment to Hz (saturating).
// Optional build macro FREQ_AVG4_EN: report the mean of the last four gates.
//   clk         system clock
//   rstn        asynchronous active-low reset
//   en          measurement enable (level)
//   cnt_in      cumulative crossing count, wraps modulo 2^CNT_W
//   freq_out    last measured frequency in Hz
//   freq_valid  one-cycle strobe when freq_out updates
//   no_signal   last completed gate saw zero crossings
//   busy        meter is in PRIME or MEASURE
module freq_gate_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             no_signal,
  output logic             busy
);

  localparam int unsigned SCALE  = CLK_HZ / GATE_CYCLES;
  localparam int unsigned PROD_W = sat_mul_width(CNT_W, SCALE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] delta_q, delta_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             nosig_q, nosig_d;
  logic             tick;
  logic [CNT_W-1:0] res;
  logic             res_ok;

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .clk (clk),
    .rstn(rstn),
    .run ((state_q != IDLE) && en),
    .tick(tick)
  );

`ifdef FREQ_AVG4_EN
  logic [CNT_W-1:0] hist_q [3];
  logic [CNT_W-1:0] hist_d [3];
  logic [2:0]       nmeas_q, nmeas_d;
  logic [CNT_W+1:0] sum;
  logic [PROD_W+1:0] avg_prod;
  logic [PROD_W-1:0] avg;

  assign sum = (CNT_W+2)'(delta_q) + (CNT_W+2)'(hist_q[0]) + (CNT_W+2)'(hist_q[1])
             + (CNT_W+2)'(hist_q[2]);
  assign avg_prod = (PROD_W+2)'(sum) * (PROD_W+2)'(SCALE);
  assign avg      = PROD_W'(avg_prod >> 2);
  assign res      = (|avg[PROD_W-1:CNT_W]) ? '1 : avg[CNT_W-1:0];
  // Result only reported once four full gates are in the history.
  assign res_ok   = (nmeas_q >= 3'd3);

  always_comb begin
    hist_d  = hist_q;
    nmeas_d = nmeas_q;
    if (!en || state_q == IDLE) begin
      hist_d  = '{default: '0};
      nmeas_d = '0;
    end else if (pend_q) begin
      hist_d[2] = hist_q[1];
      hist_d[1] = hist_q[0];
      hist_d[0] = delta_q;
      nmeas_d   = (nmeas_q == 3'd4) ? 3'd4 : nmeas_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q  <= '{default: '0};
      nmeas_q <= '0;
    end else begin
      hist_q  <= hist_d;
      nmeas_q <= nmeas_d;
    end
  end
`else
  logic [PROD_W-1:0] prod;

  assign prod   = PROD_W'(delta_q) * PROD_W'(SCALE);
  assign res    = (|prod[PROD_W-1:CNT_W]) ? '1 : prod[CNT_W-1:0];
  assign res_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    delta_d = delta_q;
    pend_d  = 1'b0;
    freq_d  = freq_q;
    valid_d = 1'b0;
    nosig_d = nosig_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          base_d  = cnt_in;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (tick) begin
          base_d  = cnt_in;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (tick) begin
          // Modular difference handles cnt_in rollover.
          delta_d = cnt_in - base_q;
          base_d  = cnt_in;
          pend_d  = en;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
    end

    if (pend_q && en) begin
      nosig_d = (delta_q == '0);
      if (res_ok) begin
        freq_d  = res;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      base_q  <= '0;
      delta_q <= '0;
      pend_q  <= 1'b0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      nosig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      delta_q <= delta_d;
      pend_q  <= pend_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      nosig_q <= nosig_d;
    end
  end

  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign no_signal  = nosig_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_freq_gate_meter.sv
module tb_freq_gate_meter;

`ifdef FREQ_AVG4_EN
  localparam int FIRST = 5002;  // edges from enable to first strobe
  localparam int SKIP  = 4;     // strobes to flush history after a disturbance
`else
  localparam int FIRST = 2002;
  localparam int SKIP  = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] cnt_in;
  logic [31:0] freq_out;
  logic        freq_valid;
  logic        no_signal;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          strobes = 0;
  int          cyc = 0;
  int          inc_period = 0;
  logic [31:0] last_freq = '0;
  logic        last_nosig = 1'b0;
  int          s0;

  freq_gate_meter #(
    .CLK_HZ     (100_000_000),
    .GATE_CYCLES(1000),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cnt_in    (cnt_in),
    .freq_out  (freq_out),
    .freq_valid(freq_valid),
    .no_signal (no_signal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then advance the input stimulus.
  task automatic step();
    @(posedge clk);
    #1;
    if (freq_valid) begin
      strobes++;
      last_freq  = freq_out;
      last_nosig = no_signal;
    end
    cyc++;
    if (inc_period != 0 && (cyc % inc_period) == 0) cnt_in = cnt_in + 32'd1;
  endtask

  task automatic wait_strobe(input string tag);
    int base;
    int n;
    base = strobes;
    n = 0;
    while (strobes == base && n < 1100) begin
      step();
      n++;
    end
    chk(tag, strobes - base, 1);
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b0;
    cnt_in = 32'd0;
    repeat (3) step();
    chk("rst_freq_out", freq_out, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_no_signal", no_signal, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Steady 1 MHz input, exact first-strobe latency.
    inc_period = 100;
    en = 1'b1;
    step();
    chk("prime_busy", busy, 1);
    repeat (FIRST - 2) step();
    chk("prime_no_strobe", strobes, 0);
    step();
    chk("first_valid", freq_valid, 1);
    chk("first_freq", freq_out, 32'd1_000_000);
    chk("first_nosig", no_signal, 0);
    step();
    chk("valid_one_cycle", freq_valid, 0);
    wait_strobe("steady_strobe");
    chk("steady_freq", last_freq, 32'd1_000_000);

    // Silence.
    inc_period = 0;
    repeat (SKIP) wait_strobe("silence_flush");
    for (int i = 0; i < 3; i++) begin
      wait_strobe("silence_strobe");
      chk("silence_freq", last_freq, 0);
      chk("silence_nosig", last_nosig, 1);
    end

    // Counter rollover.
    cnt_in = 32'hFFFF_FFFB;
    inc_period = 100;
    repeat (SKIP) wait_strobe("wrap_flush");
    for (int i = 0; i < 3; i++) begin
      wait_strobe("wrap_strobe");
      chk("wrap_freq", last_freq, 32'd1_000_000);
      chk("wrap_nosig", last_nosig, 0);
    end

`ifndef FREQ_AVG4_EN
    // Saturation boundary: 42949 counts fits, 42950 does not.
    cnt_in = cnt_in + 32'd42939;
    wait_strobe("sat_lo_strobe");
    chk("sat_lo_freq", last_freq, 32'd4_294_900_000);
    cnt_in = cnt_in + 32'd42940;
    wait_strobe("sat_hi_strobe");
    chk("sat_hi_freq", last_freq, 32'hFFFF_FFFF);
    cnt_in = cnt_in + 32'd50000;
    wait_strobe("sat_big_strobe");
    chk("sat_big_freq", last_freq, 32'hFFFF_FFFF);
    wait_strobe("sat_recover_strobe");
    chk("sat_recover_freq", last_freq, 32'd1_000_000);
`endif

    // Abort mid-MEASURE.
    wait_strobe("abort_pre_strobe");
    repeat (500) step();
    en = 1'b0;
    s0 = strobes;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_valid", freq_valid, 0);
    repeat (1200) step();
    chk("abort_no_strobe", strobes - s0, 0);
    chk("abort_hold_freq", freq_out, 32'd1_000_000);

    // Abort on the tick cycle of the gate that would produce the first result.
    en = 1'b1;
    step();
    repeat (FIRST - 3) step();
    en = 1'b0;
    step();
    chk("tick_abort_busy", busy, 0);
    repeat (10) step();
    chk("tick_abort_no_strobe", strobes - s0, 0);
    chk("tick_abort_hold", freq_out, 32'd1_000_000);

    // Re-enable: a full PRIME gate must precede the next strobe.
    en = 1'b1;
    repeat (FIRST - 1) step();
    chk("reen_no_strobe", strobes - s0, 0);
    step();
    chk("reen_valid", freq_valid, 1);
    chk("reen_freq", freq_out, 32'd1_000_000);

    // Asynchronous reset mid-gate.
    repeat (300) step();
    #3 rstn = 1'b0;
    #1;
    chk("arst_freq_out", freq_out, 0);
    chk("arst_freq_valid", freq_valid, 0);
    chk("arst_no_signal", no_signal, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    s0 = strobes;
    repeat (FIRST - 1) step();
    chk("post_rst_no_strobe", strobes - s0, 0);
    chk("post_rst_hold", freq_out, 0);
    step();
    chk("post_rst_valid", freq_valid, 1);
    chk("post_rst_freq", freq_out, 32'd1_000_000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
